// File: rtl/sample_unpacker.sv
// Unpacks fixed-width words from a show-ahead source into a continuous stream
// of SAMPLE_WIDTH-bit samples, with halt/flush control and underrun tracking.
module sample_unpacker #(
    parameter int WORD_WIDTH   = 16,
    parameter int SAMPLE_WIDTH = 3,
    parameter int MSB_FIRST    = 0,
    parameter int CNT_WIDTH    = 16,
    localparam int BUF_W       = WORD_WIDTH + SAMPLE_WIDTH - 1,
    localparam int FILL_W      = $clog2(BUF_W + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    word_empty,
    input  logic [WORD_WIDTH-1:0]   word_data,
    output logic                    word_rd,
    input  logic                    halt,
    input  logic                    flush,
    output logic                    sample_valid,
    output logic [SAMPLE_WIDTH-1:0] sample_data,
    output logic [FILL_W-1:0]       fill_level,
    output logic                    streaming,
    output logic [CNT_WIDTH-1:0]    underrun_count
);

    localparam logic [FILL_W-1:0] SW_F = FILL_W'(SAMPLE_WIDTH);
    localparam logic [FILL_W-1:0] WW_F = FILL_W'(WORD_WIDTH);

    logic [BUF_W-1:0]        buffer;
    logic [BUF_W-1:0]        shifted;
    logic [BUF_W-1:0]        incoming;
    logic [BUF_W-1:0]        buffer_nxt;
    logic [WORD_WIDTH-1:0]   word_ord;
    logic [SAMPLE_WIDTH-1:0] sample_ord;
    logic [FILL_W-1:0]       rem;
    logic                    emit;

    // Buffer bit 0 is always the oldest stream bit, so MSB-first words are
    // reversed on entry and samples reversed again on exit.
    always_comb begin
        word_ord   = word_data;
        sample_ord = buffer[SAMPLE_WIDTH-1:0];
        if (MSB_FIRST != 0) begin
            for (int i = 0; i < WORD_WIDTH; i++) begin
                word_ord[i] = word_data[WORD_WIDTH-1-i];
            end
            for (int i = 0; i < SAMPLE_WIDTH; i++) begin
                sample_ord[i] = buffer[SAMPLE_WIDTH-1-i];
            end
        end
    end

    assign emit    = !flush && !halt && (fill_level >= SW_F);
    assign rem     = emit ? (fill_level - SW_F) : fill_level;
    // Pop on the post-emit remainder so the stream never bubbles.
    assign word_rd = reset_n && !flush && !halt && !word_empty && (rem < SW_F);

    always_comb begin
        shifted    = emit ? (buffer >> SAMPLE_WIDTH) : buffer;
        incoming   = BUF_W'(word_ord);
        buffer_nxt = word_rd ? (shifted | (incoming << rem)) : shifted;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buffer         <= '0;
            fill_level     <= '0;
            sample_valid   <= 1'b0;
            sample_data    <= '0;
            streaming      <= 1'b0;
            underrun_count <= '0;
        end else if (flush) begin
            buffer       <= '0;
            fill_level   <= '0;
            sample_valid <= 1'b0;
            streaming    <= 1'b0;
        end else if (halt) begin
            sample_valid <= 1'b0;
        end else begin
            buffer       <= buffer_nxt;
            fill_level   <= word_rd ? (rem + WW_F) : rem;
            sample_valid <= emit;
            if (emit) begin
                sample_data <= sample_ord;
                streaming   <= 1'b1;
            end else if (streaming && (underrun_count != '1)) begin
                underrun_count <= underrun_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_sample_unpacker.sv
// Directed bench for sample_unpacker: default build plus MSB-first, 8-bit,
// 1-bit and 4-bit-counter builds sharing one clock and reset.
module tb_sample_unpacker;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // default build
    logic        empty_a, halt_a, flush_a, word_rd_a, valid_a, stream_a;
    logic [15:0] data_a, under_a;
    logic [2:0]  sdata_a;
    logic [4:0]  fill_a;

    // auxiliary builds share word_empty, halt=0, flush=0
    logic        empty_x;
    logic        zero = 1'b0;
    logic [15:0] data_m = 16'h8000;
    logic [15:0] data_f = 16'hFFFF;

    logic        rd_m, valid_m, stream_m;
    logic [2:0]  sdata_m;
    logic [4:0]  fill_m;
    logic [15:0] under_m;

    logic        rd_8, valid_8, stream_8;
    logic [7:0]  sdata_8;
    logic [4:0]  fill_8;
    logic [15:0] under_8;

    logic        rd_1, valid_1, stream_1;
    logic [0:0]  sdata_1;
    logic [4:0]  fill_1;
    logic [15:0] under_1;

    logic        rd_c, valid_c, stream_c;
    logic [2:0]  sdata_c;
    logic [4:0]  fill_c;
    logic [3:0]  under_c;

    sample_unpacker u_def (
        .clk(clk), .reset_n(reset_n), .word_empty(empty_a), .word_data(data_a),
        .word_rd(word_rd_a), .halt(halt_a), .flush(flush_a), .sample_valid(valid_a),
        .sample_data(sdata_a), .fill_level(fill_a), .streaming(stream_a),
        .underrun_count(under_a));

    sample_unpacker #(.MSB_FIRST(1)) u_msb (
        .clk(clk), .reset_n(reset_n), .word_empty(empty_x), .word_data(data_m),
        .word_rd(rd_m), .halt(zero), .flush(zero), .sample_valid(valid_m),
        .sample_data(sdata_m), .fill_level(fill_m), .streaming(stream_m),
        .underrun_count(under_m));

    sample_unpacker #(.SAMPLE_WIDTH(8)) u_s8 (
        .clk(clk), .reset_n(reset_n), .word_empty(empty_x), .word_data(data_f),
        .word_rd(rd_8), .halt(zero), .flush(zero), .sample_valid(valid_8),
        .sample_data(sdata_8), .fill_level(fill_8), .streaming(stream_8),
        .underrun_count(under_8));

    sample_unpacker #(.SAMPLE_WIDTH(1)) u_s1 (
        .clk(clk), .reset_n(reset_n), .word_empty(empty_x), .word_data(data_f),
        .word_rd(rd_1), .halt(zero), .flush(zero), .sample_valid(valid_1),
        .sample_data(sdata_1), .fill_level(fill_1), .streaming(stream_1),
        .underrun_count(under_1));

    sample_unpacker #(.CNT_WIDTH(4)) u_c4 (
        .clk(clk), .reset_n(reset_n), .word_empty(empty_x), .word_data(data_f),
        .word_rd(rd_c), .halt(zero), .flush(zero), .sample_valid(valid_c),
        .sample_data(sdata_c), .fill_level(fill_c), .streaming(stream_c),
        .underrun_count(under_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int pops, nsamp, cyc;
    int nm, n8, n1, nc;
    logic [2:0] exp036 [6] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};

    initial begin
        reset_n = 1'b0;
        empty_a = 1'b0;
        halt_a  = 1'b0;
        flush_a = 1'b0;
        data_a  = 16'h8000;
        empty_x = 1'b1;
        #12;
        chk("rst_word_rd", word_rd_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_sdata", sdata_a, 0);
        chk("rst_fill", fill_a, 0);
        chk("rst_streaming", stream_a, 0);
        chk("rst_underrun", under_a, 0);
        empty_a = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;

        // LSB-first: 0x8000 then 0x0000, bit 15 lands in sample 5
        empty_a = 1'b0;
        #1;
        chk("a_first_rd", word_rd_a, 1);
        tick;
        data_a = 16'h0000;
        chk("a_fill16", fill_a, 16);
        chk("a_no_valid_yet", valid_a, 0);
        for (int k = 0; k < 6; k++) begin
            chk("a_rd_timing", word_rd_a, (k == 4) ? 1 : 0);
            if (k == 4) chk("a_fill_at_pop2", fill_a, 4);
            tick;
            chk("a_valid", valid_a, 1);
            chk("a_sample", sdata_a, exp036[k]);
        end
        chk("a_fill_after", fill_a, 14);

        flush_a = 1'b1;
        #1;
        chk("flush1_rd", word_rd_a, 0);
        tick;
        flush_a = 1'b0;
        chk("flush1_fill", fill_a, 0);
        chk("flush1_streaming", stream_a, 0);
        chk("flush1_valid", valid_a, 0);

        // three all-ones words then empty
        data_a = 16'hFFFF;
        pops = 0; nsamp = 0; cyc = 0;
        while (nsamp < 16 && cyc < 60) begin
            empty_a = (pops < 3) ? 1'b0 : 1'b1;
            #1;
            if (word_rd_a) pops++;
            tick;
            cyc++;
            if (valid_a) begin
                nsamp++;
                chk("b_sample", sdata_a, 7);
            end
        end
        empty_a = 1'b1;
        chk("b_nsamp", nsamp, 16);
        chk("b_no_bubbles", cyc, 17);
        chk("b_pops", pops, 3);
        chk("b_fill0", fill_a, 0);
        chk("b_under0", under_a, 0);
        tick;
        chk("b_valid_low", valid_a, 0);
        chk("b_under1", under_a, 1);
        tick;
        chk("b_under2", under_a, 2);

        // word 0x58D1 carries samples 1,2,3,4,5
        data_a  = 16'h58D1;
        empty_a = 1'b0;
        #1;
        chk("c_rd", word_rd_a, 1);
        tick;
        empty_a = 1'b1;
        chk("c_under3", under_a, 3);
        chk("c_fill16", fill_a, 16);
        tick;
        chk("c_s1", sdata_a, 1);
        tick;
        chk("c_s2", sdata_a, 2);
        chk("c_fill10", fill_a, 10);
        halt_a  = 1'b1;
        empty_a = 1'b0;
        for (int h = 0; h < 5; h++) begin
            #1;
            chk("halt_rd", word_rd_a, 0);
            tick;
            chk("halt_valid", valid_a, 0);
            chk("halt_fill", fill_a, 10);
            chk("halt_under", under_a, 3);
        end
        halt_a  = 1'b0;
        empty_a = 1'b1;
        tick;
        chk("resume_valid", valid_a, 1);
        chk("resume_s3", sdata_a, 3);
        chk("resume_fill7", fill_a, 7);

        flush_a = 1'b1;
        empty_a = 1'b0;
        #1;
        chk("flush2_rd", word_rd_a, 0);
        tick;
        flush_a = 1'b0;
        chk("flush2_fill", fill_a, 0);
        chk("flush2_streaming", stream_a, 0);
        chk("flush2_valid", valid_a, 0);
        chk("flush2_under_hold", under_a, 3);
        #1;
        chk("realign_rd", word_rd_a, 1);
        tick;
        empty_a = 1'b1;
        tick;
        chk("realign_valid", valid_a, 1);
        chk("realign_s1", sdata_a, 1);
        chk("realign_streaming", stream_a, 1);

        // auxiliary builds: one word each, then starve
        empty_x = 1'b0;
        #1;
        chk("x_rd_m", rd_m, 1);
        chk("x_rd_8", rd_8, 1);
        chk("x_rd_1", rd_1, 1);
        chk("x_rd_c", rd_c, 1);
        tick;
        empty_x = 1'b1;
        nm = 0; n8 = 0; n1 = 0; nc = 0;
        for (int c = 0; c < 30; c++) begin
            tick;
            if (valid_m) begin
                chk("m_sample", sdata_m, (nm == 0) ? 4 : 0);
                nm++;
            end
            if (valid_8) begin
                chk("s8_sample", sdata_8, 255);
                n8++;
            end
            if (valid_1) begin
                chk("s1_sample", sdata_1, 1);
                n1++;
            end
            if (valid_c) nc++;
            if (c == 18) chk("c4_under14", under_c, 14);
            if (c == 19) chk("c4_under15", under_c, 15);
        end
        chk("m_count", nm, 5);
        chk("m_fill", fill_m, 1);
        chk("s8_count", n8, 2);
        chk("s8_fill", fill_8, 0);
        chk("s1_count", n1, 16);
        chk("s1_fill", fill_1, 0);
        chk("c4_count", nc, 5);
        chk("c4_saturated", under_c, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
